// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the cache fill controller
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int WORDS_PER_BLOCK   = 8;
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORD_IDX_BITS     = 3;

  localparam logic SEL_ICACHE = 1'b0;
  localparam logic SEL_DCACHE = 1'b1;

endpackage

// File: rtl/cache_fill_controller_if.sv
// rtl/cache_fill_controller_if.sv - miss request, main memory and fill write signals
interface cache_fill_controller_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              i_miss;
  logic [ADDR_W-1:0] i_miss_addr;
  logic              d_miss;
  logic [ADDR_W-1:0] d_miss_addr;
  logic              mem_data_valid;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              i_busy;
  logic              d_busy;
  logic              fill_sel;
  logic              fill_data_wen;
  logic [2:0]        fill_word;
  logic [DATA_W-1:0] fill_data;
  logic              fill_tag_wen;
  logic [ADDR_W-1:0] fill_block_addr;

  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data_in,
    output mem_en, mem_addr, i_busy, d_busy, fill_sel, fill_data_wen, fill_word,
           fill_data, fill_tag_wen, fill_block_addr
  );

  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data_in,
    input  mem_en, mem_addr, i_busy, d_busy, fill_sel, fill_data_wen, fill_word,
           fill_data, fill_tag_wen, fill_block_addr
  );

endinterface

// File: rtl/fill_counter.sv
// rtl/fill_counter.sv - up-counter with enable and synchronous clear
module fill_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cache_fill_controller.sv
// rtl/cache_fill_controller.sv - single-outstanding block fill engine, D-cache over I-cache
module cache_fill_controller #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cache_fill_controller_if.master  bus
);

  import cache_pkg::*;

  localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_BLOCK - 1);
  localparam logic [3:0] ISSUE_END = 4'(WORDS_PER_BLOCK);

  fill_state_t       state;
  logic              fill_sel_q;
  logic              i_busy_q;
  logic              d_busy_q;
  logic              mem_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] fill_block_addr_q;
  logic [ADDR_W-1:0] grant_addr;
  logic [ADDR_W-1:0] grant_base;
  logic [DATA_W-1:0] fill_data_c;
  logic [3:0]        issue_cnt;
  logic [3:0]        recv_cnt;
  logic [3:0]        issue_nxt;
  logic              in_fill;
  logic              recv_valid;
  logic              last_word;
  logic              cnt_clr;
  logic              grant_any;
  logic              unused_offset_bits;

  assign in_fill    = (state == FILL);
  assign recv_valid = in_fill && bus.mem_data_valid;
  assign last_word  = recv_valid && (recv_cnt == LAST_WORD);
  assign cnt_clr    = !in_fill || last_word;
  assign issue_nxt  = issue_cnt + 4'd1;

  // D-cache wins a same-cycle tie; the block base drops the byte offset
  assign grant_any  = bus.d_miss || bus.i_miss;
  assign grant_addr = bus.d_miss ? bus.d_miss_addr : bus.i_miss_addr;
  assign grant_base = {grant_addr[ADDR_W-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
  assign unused_offset_bits = ^grant_addr[BLOCK_OFFSET_BITS-1:0];

  fill_counter #(.W(4)) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (in_fill && mem_en_q),
    .clr   (cnt_clr),
    .count (issue_cnt)
  );

  fill_counter #(.W(4)) u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (recv_valid),
    .clr   (cnt_clr),
    .count (recv_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      fill_sel_q        <= SEL_ICACHE;
      fill_block_addr_q <= '0;
      i_busy_q          <= 1'b0;
      d_busy_q          <= 1'b0;
      mem_en_q          <= 1'b0;
      mem_addr_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state             <= FILL;
            fill_sel_q        <= bus.d_miss ? SEL_DCACHE : SEL_ICACHE;
            fill_block_addr_q <= grant_base;
            i_busy_q          <= !bus.d_miss;
            d_busy_q          <= bus.d_miss;
            mem_en_q          <= 1'b1;
            mem_addr_q        <= grant_base;
          end
        end
        FILL: begin
          // Word offsets are spliced in rather than added, so no carry past the block
          if (mem_en_q) begin
            if (issue_nxt < ISSUE_END) begin
              mem_addr_q <= {fill_block_addr_q[ADDR_W-1:BLOCK_OFFSET_BITS],
                             issue_nxt[WORD_IDX_BITS-1:0], 1'b0};
            end else begin
              mem_en_q   <= 1'b0;
              mem_addr_q <= '0;
            end
          end
          if (last_word) begin
            state    <= IDLE;
            i_busy_q <= 1'b0;
            d_busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fill_data_c = recv_valid ? bus.mem_data_in : '0;

  assign bus.mem_en          = mem_en_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.i_busy          = i_busy_q;
  assign bus.d_busy          = d_busy_q;
  assign bus.fill_sel        = fill_sel_q;
  assign bus.fill_data_wen   = recv_valid;
  assign bus.fill_word       = recv_cnt[WORD_IDX_BITS-1:0];
  assign bus.fill_data       = fill_data_c;
  assign bus.fill_tag_wen    = last_word;
  assign bus.fill_block_addr = fill_block_addr_q;

endmodule

// File: tb/tb_cache_fill_controller.sv
// tb/tb_cache_fill_controller.sv - randomized and directed bench against a transaction-level model
module tb_cache_fill_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_fill_controller_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  cache_fill_controller #(.WORDS_PER_BLOCK(8), .ADDR_W(16), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Memory: in-order returns, latency drawn per read
  int pend_t[$];
  int last_ret = 0;
  int lat_min = 4;
  int lat_max = 4;

  // Transaction model of the fill in progress
  bit          m_fill = 0;
  bit          m_sel = 0;
  logic [15:0] m_blk = '0;
  int          m_issue = 0;
  int          m_recv = 0;

  // Observations for the hand-computed expectations
  int          en_cyc[$];
  logic [15:0] en_addr[$];
  int          tag_cyc[$];
  logic [15:0] tag_blk[$];
  bit          tag_sel[$];
  int          busy_first = -1;
  int          wen_first = -1;
  int          wen_cnt = 0;
  bit          tag_now = 0;
  bit          tag_now_sel = 0;
  bit          drop_i = 0;
  bit          drop_d = 0;

  logic        e_ibusy, e_dbusy, e_en, e_wen, e_tag, e_sel;
  logic [15:0] e_addr, e_blk, e_data;
  logic [2:0]  e_word;
  int          r;

  always @(negedge clk) begin
    if (!rst_n) begin
      {e_ibusy, e_dbusy, e_en, e_wen, e_tag, e_sel} = '0;
      e_addr = '0; e_blk = '0; e_data = '0; e_word = '0;
    end else begin
      e_ibusy = m_fill && !m_sel;
      e_dbusy = m_fill && m_sel;
      e_en    = m_fill && (m_issue < 8);
      e_addr  = e_en ? 16'(m_blk + 2 * m_issue) : 16'h0;
      e_wen   = m_fill && bus.mem_data_valid;
      e_tag   = e_wen && (m_recv == 7);
      e_word  = m_fill ? 3'(m_recv) : 3'd0;
      e_data  = e_wen ? bus.mem_data_in : 16'h0;
      e_sel   = m_sel;
      e_blk   = m_blk;
    end
    chk("i_busy", bus.i_busy, e_ibusy);
    chk("d_busy", bus.d_busy, e_dbusy);
    chk("mem_en", bus.mem_en, e_en);
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("fill_data_wen", bus.fill_data_wen, e_wen);
    chk("fill_word", bus.fill_word, e_word);
    chk("fill_tag_wen", bus.fill_tag_wen, e_tag);
    chk("fill_sel", bus.fill_sel, e_sel);
    chk("fill_block_addr", bus.fill_block_addr, e_blk);
    if (e_wen || !rst_n) chk("fill_data", bus.fill_data, e_data);

    if ((bus.i_busy || bus.d_busy) && busy_first < 0) busy_first = cyc;
    if (bus.mem_en) begin
      en_cyc.push_back(cyc);
      en_addr.push_back(bus.mem_addr);
      r = cyc + $urandom_range(lat_max, lat_min);
      if (r <= last_ret) r = last_ret + 1;
      last_ret = r;
      pend_t.push_back(r);
    end
    if (bus.fill_data_wen) begin
      wen_cnt++;
      if (wen_first < 0) wen_first = cyc;
    end
    tag_now = bus.fill_tag_wen;
    tag_now_sel = bus.fill_sel;
    if (bus.fill_tag_wen) begin
      tag_cyc.push_back(cyc);
      tag_blk.push_back(bus.fill_block_addr);
      tag_sel.push_back(bus.fill_sel);
    end

    if (!rst_n) begin
      m_fill = 0; m_sel = 0; m_blk = '0; m_issue = 0; m_recv = 0;
    end else if (m_fill) begin
      if (m_issue < 8) m_issue++;
      if (bus.mem_data_valid) begin
        m_recv++;
        if (m_recv == 8) m_fill = 0;
      end
    end else if (bus.d_miss || bus.i_miss) begin
      m_fill  = 1;
      m_sel   = bus.d_miss;
      m_blk   = (bus.d_miss ? bus.d_miss_addr : bus.i_miss_addr) & 16'hFFF0;
      m_issue = 0;
      m_recv  = 0;
    end
  end

  task automatic obs_clear();
    en_cyc.delete(); en_addr.delete();
    tag_cyc.delete(); tag_blk.delete(); tag_sel.delete();
    busy_first = -1; wen_first = -1; wen_cnt = 0;
  endtask

  task automatic tick_rise();
    @(posedge clk);
    #1;
    if (drop_i) begin bus.i_miss = 1'b0; drop_i = 0; end
    if (drop_d) begin bus.d_miss = 1'b0; drop_d = 0; end
    bus.mem_data_valid = 1'b0;
    bus.mem_data_in = 16'h0;
    if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
      void'(pend_t.pop_front());
      bus.mem_data_valid = 1'b1;
      bus.mem_data_in = 16'($urandom);
    end
  endtask

  // A requester releases its miss once it sees its own tag write
  task automatic tick_fall();
    @(negedge clk);
    #1;
    if (tag_now) begin
      if (tag_now_sel) drop_d = 1;
      else drop_i = 1;
    end
  endtask

  task automatic cycle();
    tick_rise();
    tick_fall();
  endtask

  task automatic wait_tags(input int n, input int budget);
    int b;
    b = budget;
    while (tag_cyc.size() < n && b > 0) begin
      cycle();
      b--;
    end
    chk("tag_timeout", (tag_cyc.size() >= n), 1'b1);
  endtask

  task automatic settle();
    bit done;
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      tick_rise();
      bus.i_miss = 1'b0;
      bus.d_miss = 1'b0;
      tick_fall();
      done = !m_fill && (pend_t.size() == 0);
    end
    chk("settle_timeout", done, 1'b1);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_miss = 0; bus.i_miss_addr = '0;
    bus.d_miss = 0; bus.d_miss_addr = '0;
    bus.mem_data_valid = 0; bus.mem_data_in = '0;

    repeat (3) cycle();
    chk("rst_mem_en", bus.mem_en, 1'b0);
    chk("rst_fill_block_addr", bus.fill_block_addr, 16'h0);
    chk("rst_fill_sel", bus.fill_sel, 1'b0);
    tick_rise();
    rst_n = 1'b1;
    tick_fall();
    cycle();

    // I-miss only
    obs_clear();
    tick_rise(); bus.i_miss = 1'b1; bus.i_miss_addr = 16'h1236; tick_fall();
    wait_tags(1, 40);
    repeat (3) cycle();
    chk("i_tag_minus_busy", 32'(tag_cyc[0] - busy_first), 32'd11);
    chk("i_first_en_cyc", 32'(en_cyc[0] - busy_first), 32'd0);
    chk("i_en_count", en_addr.size(), 32'd8);
    chk("i_first_addr", en_addr[0], 16'h1230);
    chk("i_last_addr", en_addr[7], 16'h123E);
    chk("i_first_wen_delay", 32'(wen_first - busy_first), 32'd4);
    chk("i_wen_count", wen_cnt, 32'd8);
    chk("i_tag_blk", tag_blk[0], 16'h1230);
    chk("i_tag_sel", tag_sel[0], 1'b0);
    settle();

    // Simultaneous misses
    obs_clear();
    tick_rise();
    bus.d_miss = 1'b1; bus.d_miss_addr = 16'h4008;
    bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0020;
    tick_fall();
    wait_tags(2, 60);
    chk("sim_d_first_addr", en_addr[0], 16'h4000);
    chk("sim_d_tag_sel", tag_sel[0], 1'b1);
    chk("sim_d_tag_blk", tag_blk[0], 16'h4000);
    chk("sim_i_first_addr", en_addr[8], 16'h0020);
    chk("sim_i_issue_gap", 32'(en_cyc[8] - tag_cyc[0]), 32'd2);
    chk("sim_i_tag_sel", tag_sel[1], 1'b0);
    chk("sim_i_tag_blk", tag_blk[1], 16'h0020);
    chk("sim_tag_spacing", 32'(tag_cyc[1] - tag_cyc[0]), 32'd13);
    settle();

    // Top block, no wrap
    obs_clear();
    tick_rise(); bus.d_miss = 1'b1; bus.d_miss_addr = 16'hFFFA; tick_fall();
    wait_tags(1, 40);
    chk("top_first_addr", en_addr[0], 16'hFFF0);
    chk("top_last_addr", en_addr[7], 16'hFFFE);
    chk("top_tag_blk", tag_blk[0], 16'hFFF0);
    settle();

    // Flush: request dropped at T+3
    obs_clear();
    tick_rise(); bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0456; tick_fall();
    cycle(); cycle();
    tick_rise(); bus.i_miss = 1'b0; tick_fall();
    wait_tags(1, 40);
    chk("flush_wen_count", wen_cnt, 32'd8);
    chk("flush_tag_time", 32'(tag_cyc[0] - busy_first), 32'd11);
    chk("flush_tag_blk", tag_blk[0], 16'h0450);
    settle();

    // Async reset at T+6
    obs_clear();
    tick_rise(); bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0A16; tick_fall();
    repeat (5) cycle();
    tick_rise(); rst_n = 1'b0; bus.i_miss = 1'b0; tick_fall();
    chk("rstmid_mem_en", bus.mem_en, 1'b0);
    chk("rstmid_i_busy", bus.i_busy, 1'b0);
    chk("rstmid_wen_before", wen_cnt, 32'd1);
    tick_rise(); rst_n = 1'b1; tick_fall();
    obs_clear();
    repeat (8) cycle();
    chk("rstmid_wen_after", wen_cnt, 32'd0);
    chk("rstmid_tag_after", tag_cyc.size(), 32'd0);
    chk("rstmid_busy_after", busy_first, 32'hFFFF_FFFF);
    settle();

    // Stray return in IDLE
    obs_clear();
    tick_rise(); bus.mem_data_valid = 1'b1; bus.mem_data_in = 16'hBEEF; tick_fall();
    cycle();
    chk("stray_wen", wen_cnt, 32'd0);
    chk("stray_busy", busy_first, 32'hFFFF_FFFF);
    chk("stray_en", en_addr.size(), 32'd0);

    // Random traffic with variable memory latency
    lat_min = 4; lat_max = 7;
    obs_clear();
    for (int n = 0; n < 1500; n++) begin
      tick_rise();
      if (!bus.d_miss) begin
        if ($urandom_range(9, 0) == 0) begin
          bus.d_miss = 1'b1; bus.d_miss_addr = 16'($urandom);
        end
      end else if (m_fill && m_sel) begin
        if ($urandom_range(19, 0) == 0) bus.d_miss_addr = 16'($urandom);
        if ($urandom_range(39, 0) == 0) bus.d_miss = 1'b0;
      end
      if (!bus.i_miss) begin
        if ($urandom_range(7, 0) == 0) begin
          bus.i_miss = 1'b1; bus.i_miss_addr = 16'($urandom);
        end
      end else if (m_fill && !m_sel) begin
        if ($urandom_range(19, 0) == 0) bus.i_miss_addr = 16'($urandom);
        if ($urandom_range(39, 0) == 0) bus.i_miss = 1'b0;
      end
      if (!m_fill && pend_t.size() == 0 && $urandom_range(7, 0) == 0) begin
        bus.mem_data_valid = 1'b1;
        bus.mem_data_in = 16'($urandom);
      end
      tick_fall();
    end
    settle();
    chk("rand_some_fills", (tag_cyc.size() > 20), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
